ttl_step_sequencer: RTL and testbench
=====================================

Name: ttl_step_sequencer

Overview:
- CPU timing-state generator that sits directly upstream of the 3-to-8 step decoder.
- Produces the binary microcycle step index (Step) and decoder enable (StepEn) that select one active timing line per clock.
- Handles run/halt, single-instruction stepping, memory wait stalls and variable-length instructions ended early by microcode.

Parameters:
- STEP_W, 3, width of the step index; matches the decoder select input.
- MAX_STEP, 7, last legal step; must be < 2**STEP_W.

Ports:
- Clk  input  1  system clock, rising-edge.
- Rst_n  input  1  asynchronous, active-low reset.
- Run  input  1  level; 1 = free-run instructions, 0 = halt at the next instruction boundary.
- StepReq  input  1  one-cycle pulse; from HALTED, execute exactly one instruction.
- Ready  input  1  0 = memory wait; hold the current step.
- EndInstr  input  1  microcode flag; the current step is the last of this instruction.
- Step  output  STEP_W  current step index, to the decoder In.
- StepEn  output  1  decoder enable; 1 while executing.
- InstrStart  output  1  high for exactly the first cycle of step 0 of each instruction.
- Halted  output  1  1 in HALTED state.
- Overrun  output  1  sticky; instruction passed MAX_STEP without EndInstr.

Behaviour:
- Reset (async, Rst_n=0): state HALTED, Step=0, StepEn=0, InstrStart=0, Halted=1, Overrun=0. This applies immediately, including mid-instruction; no partial instruction resumes.
- All outputs are registered. Transitions are on the Clk rising edge.
- States: HALTED, RUN, SINGLE.
- HALTED:
  - StepEn=0, Step=0.
  - Run=1 → RUN.
  - Else StepReq=1 → SINGLE.
  - If Run and StepReq are both set, RUN wins.
  - On leaving HALTED, the next cycle has StepEn=1, Step=0, InstrStart=1.
- RUN / SINGLE:
  - StepEn=1, Halted=0.
  - Ready=0: Step, state and Overrun are held. InstrStart is 0 during the hold even if Step=0.
  - Ready=1 and (EndInstr=1 or Step==MAX_STEP): instruction boundary. Step←0.
  - Ready=1 otherwise: Step←Step+1.
  - Step==MAX_STEP, Ready=1, EndInstr=0: Overrun←1 (sticky until reset). Step still wraps to 0.
- At an instruction boundary:
  - RUN with Run=1 → stay RUN; InstrStart=1 next cycle.
  - RUN with Run=0 → HALTED.
  - SINGLE with Run=1 → RUN.
  - SINGLE with Run=0 → HALTED.
- Run deasserted mid-instruction: the instruction completes; halt occurs only at the boundary.
- StepReq outside HALTED is ignored and is not queued.
- EndInstr is sampled only when Ready=1. EndInstr at step 0 gives a 1-step instruction; InstrStart repeats every cycle in that case.
- Latency:
  - Run assertion to first StepEn: 1 clock.
  - Boundary to Halted=1: 1 clock.

Optional Feature:
- Macro: STEP_SEQ_TIMED_EN.
- Defined: Step, StepEn and InstrStart are driven through min:typ:max clock-to-output delays of #(0:25:40), modelling 74LS161 + gating propagation.
- Undefined: zero-delay outputs; identical cycle behaviour.

Decomposition:
- Shared package: state encodings (ST_HALTED=2'd0, ST_RUN=2'd1, ST_SINGLE=2'd2) and the default STEP_W / MAX_STEP constants used by both this block and the decoder instantiation.
- Sub-module ttl_step_counter:
  - 74161-style STEP_W counter with async clear, synchronous clear and count enable.
  - The sequencer drives count enable = active & Ready, and sync clear = boundary.

Test Plan:
- Reset with Run=1 held → after Rst_n rises, one clock later: StepEn=1, Step=0, InstrStart=1. Step then counts 0..4 with EndInstr pulsed at step 4, and returns to 0 with InstrStart=1.
- Ready=0 for 3 cycles at step 2 → Step stays 2 for 4 cycles total, then 3. InstrStart stays 0 throughout.
- Run dropped at step 1, EndInstr at step 3 → steps 2 and 3 still execute. Next clock: Halted=1, StepEn=0, Step=0.
- HALTED, StepReq pulse, Run=0 → exactly one instruction (EndInstr at step 5) runs, then Halted=1. A second StepReq issued mid-instruction has no effect.
- EndInstr never asserted → after step 7, Step=0 and Overrun=1. Overrun stays 1 through further instructions until Rst_n=0.
- Rst_n pulled low asynchronously at step 4 (between edges) → outputs clear immediately to Step=0, StepEn=0, Halted=1.

Source files
------------

// File: rtl/ttl_step_sequencer_pkg.sv
// Shared encodings and default sizing for the step sequencer
// and the downstream 3-to-8 step decoder.
package ttl_step_sequencer_pkg;

  localparam int STEP_W_DEF   = 3;
  localparam int MAX_STEP_DEF = 7;

  typedef enum logic [1:0] {
    ST_HALTED = 2'd0,
    ST_RUN    = 2'd1,
    ST_SINGLE = 2'd2
  } state_t;

endpackage

// File: rtl/ttl_step_counter.sv
// 74161-style step counter: async clear, sync clear
// (priority over count) and count enable.
module ttl_step_counter
  import ttl_step_sequencer_pkg::*;
#(
  parameter int W = STEP_W_DEF
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_clr,
  input  logic         i_en,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q <= '0;
    end else if (i_clr) begin
      r_q <= '0;
    end else if (i_en) begin
      r_q <= r_q + 1'b1;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/ttl_step_sequencer.sv
// CPU timing-state generator feeding the step decoder.
// Define STEP_SEQ_TIMED_EN for 74LS-style output delays.
module ttl_step_sequencer
  import ttl_step_sequencer_pkg::*;
#(
  parameter int STEP_W   = STEP_W_DEF,
  parameter int MAX_STEP = MAX_STEP_DEF
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Run,
  input  logic              StepReq,
  input  logic              Ready,
  input  logic              EndInstr,
  output logic [STEP_W-1:0] Step,
  output logic              StepEn,
  output logic              InstrStart,
  output logic              Halted,
  output logic              Overrun
);

  localparam logic [STEP_W-1:0] LP_MAX =
    STEP_W'(MAX_STEP);

  state_t r_state;
  state_t w_state_nxt;

  logic r_step_en;
  logic r_instr_start;
  logic r_halted;
  logic r_overrun;

  logic              w_active;
  logic              w_adv;
  logic              w_at_max;
  logic              w_boundary;
  logic              w_ovr_set;
  logic              w_start_nxt;
  logic [STEP_W-1:0] w_step;

  assign w_active   = (r_state != ST_HALTED);
  assign w_adv      = w_active & Ready;
  assign w_at_max   = (w_step == LP_MAX);
  assign w_boundary = w_adv & (EndInstr | w_at_max);
  assign w_ovr_set  = w_adv & w_at_max & ~EndInstr;

  ttl_step_counter #(
    .W (STEP_W)
  ) u_cnt (
    .i_clk   (Clk),
    .i_rst_n (Rst_n),
    .i_clr   (w_boundary),
    .i_en    (w_adv),
    .o_q     (w_step)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_start_nxt = 1'b0;
    unique case (r_state)
      ST_HALTED: begin
        if (Run) begin
          w_state_nxt = ST_RUN;
          w_start_nxt = 1'b1;
        end else if (StepReq) begin
          w_state_nxt = ST_SINGLE;
          w_start_nxt = 1'b1;
        end
      end
      ST_RUN, ST_SINGLE: begin
        if (w_boundary) begin
          if (Run) begin
            w_state_nxt = ST_RUN;
            w_start_nxt = 1'b1;
          end else begin
            w_state_nxt = ST_HALTED;
          end
        end
      end
      default: begin
        w_state_nxt = ST_HALTED;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state       <= ST_HALTED;
      r_step_en     <= 1'b0;
      r_instr_start <= 1'b0;
      r_halted      <= 1'b1;
      r_overrun     <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_step_en     <= (w_state_nxt != ST_HALTED);
      r_instr_start <= w_start_nxt;
      r_halted      <= (w_state_nxt == ST_HALTED);
      r_overrun     <= r_overrun | w_ovr_set;
    end
  end

`ifdef STEP_SEQ_TIMED_EN
  // Counter clock-to-Q plus enable gating delay.
  assign #(0:25:40) Step       = w_step;
  assign #(0:25:40) StepEn     = r_step_en;
  assign #(0:25:40) InstrStart = r_instr_start;
`else
  assign Step       = w_step;
  assign StepEn     = r_step_en;
  assign InstrStart = r_instr_start;
`endif

  assign Halted  = r_halted;
  assign Overrun = r_overrun;

endmodule

// File: tb/tb_ttl_step_sequencer.sv
// Directed bench for ttl_step_sequencer; inputs change and
// outputs are sampled on the falling clock edge.
module tb_ttl_step_sequencer;

  logic       Clk;
  logic       Rst_n;
  logic       Run;
  logic       StepReq;
  logic       Ready;
  logic       EndInstr;
  logic [2:0] Step;
  logic       StepEn;
  logic       InstrStart;
  logic       Halted;
  logic       Overrun;

  int checks;
  int failures;

  ttl_step_sequencer dut (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .Run        (Run),
    .StepReq    (StepReq),
    .Ready      (Ready),
    .EndInstr   (EndInstr),
    .Step       (Step),
    .StepEn     (StepEn),
    .InstrStart (InstrStart),
    .Halted     (Halted),
    .Overrun    (Overrun)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic test_reset;
    Rst_n    = 1'b1;
    Run      = 1'b1;
    StepReq  = 1'b0;
    Ready    = 1'b1;
    EndInstr = 1'b0;
    #2 Rst_n = 1'b0;
    #1;
    checks++;
    if ({Step, StepEn, InstrStart, Halted, Overrun}
        !== {3'd0, 1'b0, 1'b0, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL reset_state got=%b/%b/%b/%b/%b exp=0/0/0/1/0",
               Step, StepEn, InstrStart, Halted, Overrun);
    end
    @(negedge Clk);
    @(negedge Clk);
    Rst_n = 1'b1;
    @(negedge Clk);
    checks++;
    if ({Step, StepEn, InstrStart, Halted}
        !== {3'd0, 1'b1, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL run_start got=%0d/%b/%b/%b exp=0/1/1/0",
               Step, StepEn, InstrStart, Halted);
    end
    for (int k = 1; k <= 4; k++) begin
      @(negedge Clk);
      checks++;
      if (Step !== 3'(k) || InstrStart !== 1'b0) begin
        failures++;
        $display("FAIL count_step got=%0d/%b exp=%0d/0",
                 Step, InstrStart, k);
      end
      EndInstr = (k == 4);
    end
    @(negedge Clk);
    EndInstr = 1'b0;
    checks++;
    if (Step !== 3'd0 || InstrStart !== 1'b1) begin
      failures++;
      $display("FAIL end_wrap got=%0d/%b exp=0/1",
               Step, InstrStart);
    end
  endtask

  task automatic test_ready_hold;
    @(negedge Clk);
    @(negedge Clk);
    checks++;
    if (Step !== 3'd2) begin
      failures++;
      $display("FAIL hold_pre got=%0d exp=2", Step);
    end
    Ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge Clk);
      if (k == 2) Ready = 1'b1;
      checks++;
      if (Step !== 3'd2 || InstrStart !== 1'b0
          || StepEn !== 1'b1) begin
        failures++;
        $display("FAIL hold_step got=%0d/%b/%b exp=2/0/1",
                 Step, InstrStart, StepEn);
      end
    end
    @(negedge Clk);
    checks++;
    if (Step !== 3'd3) begin
      failures++;
      $display("FAIL hold_release got=%0d exp=3", Step);
    end
    EndInstr = 1'b1;
    @(negedge Clk);
    EndInstr = 1'b0;
    Ready    = 1'b0;
    checks++;
    if (Step !== 3'd0 || InstrStart !== 1'b1) begin
      failures++;
      $display("FAIL early_end got=%0d/%b exp=0/1",
               Step, InstrStart);
    end
    @(negedge Clk);
    Ready = 1'b1;
    checks++;
    if (Step !== 3'd0 || InstrStart !== 1'b0) begin
      failures++;
      $display("FAIL hold_step0 got=%0d/%b exp=0/0",
               Step, InstrStart);
    end
  endtask

  task automatic test_run_drop;
    @(negedge Clk);
    checks++;
    if (Step !== 3'd1) begin
      failures++;
      $display("FAIL drop_s1 got=%0d exp=1", Step);
    end
    Run = 1'b0;
    @(negedge Clk);
    checks++;
    if (Step !== 3'd2 || StepEn !== 1'b1
        || Halted !== 1'b0) begin
      failures++;
      $display("FAIL drop_s2 got=%0d/%b/%b exp=2/1/0",
               Step, StepEn, Halted);
    end
    @(negedge Clk);
    checks++;
    if (Step !== 3'd3) begin
      failures++;
      $display("FAIL drop_s3 got=%0d exp=3", Step);
    end
    EndInstr = 1'b1;
    @(negedge Clk);
    EndInstr = 1'b0;
    checks++;
    if ({Step, StepEn, Halted, InstrStart}
        !== {3'd0, 1'b0, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL drop_halt got=%0d/%b/%b/%b exp=0/0/1/0",
               Step, StepEn, Halted, InstrStart);
    end
    @(negedge Clk);
    checks++;
    if (Halted !== 1'b1 || StepEn !== 1'b0) begin
      failures++;
      $display("FAIL drop_idle got=%b/%b exp=1/0",
               Halted, StepEn);
    end
  endtask

  task automatic test_single;
    StepReq = 1'b1;
    @(negedge Clk);
    StepReq = 1'b0;
    checks++;
    if ({Step, StepEn, InstrStart, Halted}
        !== {3'd0, 1'b1, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL single_start got=%0d/%b/%b/%b exp=0/1/1/0",
               Step, StepEn, InstrStart, Halted);
    end
    for (int k = 1; k <= 5; k++) begin
      @(negedge Clk);
      checks++;
      if (Step !== 3'(k) || StepEn !== 1'b1) begin
        failures++;
        $display("FAIL single_step got=%0d/%b exp=%0d/1",
                 Step, StepEn, k);
      end
      StepReq  = (k == 2);
      EndInstr = (k == 5);
    end
    @(negedge Clk);
    EndInstr = 1'b0;
    checks++;
    if ({Step, StepEn, Halted}
        !== {3'd0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL single_halt got=%0d/%b/%b exp=0/0/1",
               Step, StepEn, Halted);
    end
    @(negedge Clk);
    checks++;
    if (Halted !== 1'b1 || StepEn !== 1'b0) begin
      failures++;
      $display("FAIL single_noqueue got=%b/%b exp=1/0",
               Halted, StepEn);
    end
  endtask

  task automatic test_overrun;
    checks++;
    if (Overrun !== 1'b0) begin
      failures++;
      $display("FAIL ovr_pre got=%b exp=0", Overrun);
    end
    Run     = 1'b1;
    StepReq = 1'b1;
    @(negedge Clk);
    StepReq = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge Clk);
      checks++;
      if (Step !== 3'(k) || Overrun !== 1'b0) begin
        failures++;
        $display("FAIL ovr_step got=%0d/%b exp=%0d/0",
                 Step, Overrun, k);
      end
    end
    @(negedge Clk);
    checks++;
    if ({Step, Overrun, InstrStart, Halted}
        !== {3'd0, 1'b1, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL ovr_wrap got=%0d/%b/%b/%b exp=0/1/1/0",
               Step, Overrun, InstrStart, Halted);
    end
    @(negedge Clk);
    EndInstr = 1'b1;
    @(negedge Clk);
    EndInstr = 1'b0;
    checks++;
    if (Step !== 3'd0 || Overrun !== 1'b1) begin
      failures++;
      $display("FAIL ovr_sticky got=%0d/%b exp=0/1",
               Step, Overrun);
    end
  endtask

  task automatic test_async_reset;
    for (int k = 1; k <= 4; k++) @(negedge Clk);
    checks++;
    if (Step !== 3'd4) begin
      failures++;
      $display("FAIL areset_pre got=%0d exp=4", Step);
    end
    #2 Rst_n = 1'b0;
    #1;
    checks++;
    if ({Step, StepEn, Halted, Overrun, InstrStart}
        !== {3'd0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL areset got=%0d/%b/%b/%b/%b exp=0/0/1/0/0",
               Step, StepEn, Halted, Overrun, InstrStart);
    end
    @(negedge Clk);
    checks++;
    if (Halted !== 1'b1 || StepEn !== 1'b0) begin
      failures++;
      $display("FAIL areset_hold got=%b/%b exp=1/0",
               Halted, StepEn);
    end
  endtask

  task automatic test_one_step;
    EndInstr = 1'b1;
    Rst_n    = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge Clk);
      checks++;
      if ({Step, StepEn, InstrStart}
          !== {3'd0, 1'b1, 1'b1}) begin
        failures++;
        $display("FAIL one_step got=%0d/%b/%b exp=0/1/1",
                 Step, StepEn, InstrStart);
      end
    end
    EndInstr = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_ready_hold();
    test_run_drop();
    test_single();
    test_overrun();
    test_async_reset();
    test_one_step();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
